// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions for the fetch sequencer and the control unit:
// next-PC select codes, opcode constants, sequencer states and the IR layout.
package fetch_sequencer_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_src_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FUNC_ADD = 6'b100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EXEC,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;
    logic [5:0] func;
  } instr_t;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    return {{(XLEN-18){imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus between the fetch sequencer
// (master) and the instruction memory (slave).
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer_next_pc_gen.sv
// Combinational next-PC selection: sequential, PC-relative branch, or
// region-local jump. All arithmetic wraps modulo 2^32.
module fetch_sequencer_next_pc_gen
  import fetch_sequencer_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [25:0]     instr_low,
  input  pc_src_e         pc_src,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc
);

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    next_pc = pc_plus4;
    case (pc_src)
      PC_BRANCH: next_pc = pc_plus4 + branch_offset(instr_low[15:0]);
      PC_JUMP:   next_pc = {pc_plus4[31:28], instr_low, 2'b00};
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches one instruction per REQ/WAIT/EXEC
// round trip, exposes the decoded IR fields and commits the next PC.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  fetch_sequencer_if.master imem,
  input  logic              PCWre,
  input  logic [1:0]        PCSrc,
  output logic              instr_valid,
  output logic [5:0]        OpCode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        sa,
  output logic [5:0]        func,
  output logic [15:0]       immediate,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              halted,
  output logic [31:0]       retired
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  instr_t            ir_q, ir_d;
  logic [31:0]       retired_q, retired_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] next_pc;
  logic [31:0]       ir_bits;

  assign ir_bits = ir_q;

  fetch_sequencer_next_pc_gen u_next_pc_gen (
    .pc        (pc_q),
    .instr_low (ir_bits[25:0]),
    .pc_src    (pc_src_e'(PCSrc)),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        // The response is only accepted here; strays in other states are dropped.
        if (imem.imem_rvalid) begin
          ir_d    = instr_t'(imem.imem_rdata);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (PCWre) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
          state_d   = ST_REQ;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the upcoming state.
    req_d    = (state_d == ST_REQ);
    valid_d  = (state_d == ST_EXEC);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      // NOTE: IR is a single register rather than a memory array, so it is
      // reset along with the rest of the state and never shows X after reset.
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = valid_q;
  assign halted         = halted_q;
  assign retired        = retired_q;
  assign pc             = pc_q;

  assign OpCode    = ir_q.opcode;
  assign rs        = ir_q.rs;
  assign rt        = ir_q.rt;
  assign rd        = ir_q.rd;
  assign sa        = ir_q.sa;
  assign func      = ir_q.func;
  assign immediate = ir_bits[15:0];

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-side counterpart of the single-cycle control unit: owns the PC, fetches instruction words over a request/response handshake, and presents the decoded fields (OpCode, func, register fields, immediate) to the control unit and datapath. It then consumes the control unit's PCWre/PCSrc verdict to select and commit the next PC. It sits between the instruction memory and the control unit/register file. This replaces a free-running combinational PC path with an explicit fetch/execute sequence that tolerates variable memory latency.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC / instruction address width (fixed at 32 for jump-target math).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  one-cycle fetch request strobe.
- imem_addr  out  32  fetch address (= PC), valid while imem_req=1.
- imem_rvalid  in  1  instruction word valid.
- imem_rdata  in  32  instruction word.
- PCWre  in  1  from control unit; 1 = commit next PC, 0 = halt.
- PCSrc  in  2  from control unit; next-PC select.
- instr_valid  out  1  IR holds the instruction being executed this cycle.
- OpCode  out  6  IR[31:26].
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- sa  out  5  IR[10:6].
- func  out  6  IR[5:0].
- immediate  out  16  IR[15:0].
- pc  out  32  current PC.
- pc_plus4  out  32  PC+4, for link/branch use.
- halted  out  1  sequencer in HALT.
- retired  out  32  count of committed instructions.

## Operation
- States: IDLE, REQ, WAIT, EXEC, HALT. Reset → IDLE.
- IDLE: one cycle, then → REQ. Ignores imem_rvalid.
- REQ: imem_req=1, imem_addr=pc for exactly one cycle; → WAIT.
- WAIT: on imem_rvalid=1, IR←imem_rdata and → EXEC. Otherwise stay in WAIT indefinitely.
- EXEC: instr_valid=1 for exactly one cycle; the control unit decodes IR combinationally. At the end of the cycle:
  - If PCWre=1: pc←next_pc, retired←retired+1, → REQ.
  - If PCWre=0: pc unchanged, retired unchanged, → HALT.
- HALT: absorbing state; halted=1; only Reset exits.
- next_pc, derived from PCSrc:
  - 00: pc+4.
  - 01: pc+4 + (sign_extend(immediate)<<2).
  - 10: {pc_plus4[31:28], IR[25:0], 2'b00}.
  - 11: reserved, treated as pc+4.
- Arithmetic:
  - All PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
  - Branch offsets may be negative.
  - retired wraps modulo 2^32.
- IR fields are driven continuously from IR. Their values are meaningful only while instr_valid=1.

## Timing
- Reset values:
  - pc=RESET_PC, IR=0, retired=0.
  - imem_req=0, instr_valid=0, halted=0.
  - imem_addr=RESET_PC, pc_plus4=RESET_PC+4.
- First imem_req occurs on the 2nd rising edge after Reset deasserts (IDLE takes one cycle).
- imem_rvalid is sampled only in WAIT, so the earliest response is the cycle after imem_req. With that zero-wait response, throughput is 3 cycles per instruction (REQ, WAIT, EXEC).
- imem_rvalid during REQ, EXEC, IDLE, or HALT is ignored and produces no error.
- Reset asserted mid-WAIT or mid-EXEC:
  - Immediate return to reset values.
  - The outstanding response is discarded (not sampled in IDLE).
  - No PC commit and no retired increment.
- PCWre/PCSrc are sampled only on the EXEC→next edge.

## Structure
- Shared CPU package holds:
  - PCSrc encodings (PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_JUMP=2'b10).
  - Opcode constants shared with the control unit.
  - The state enumeration.
- One natural sub-module, next_pc_gen: combinational next-PC mux plus adder, fed by pc, IR and PCSrc.
- FSM, IR and counters live in fetch_sequencer.

## Test plan
- Reset release, rdata=ADD (opcode 0, func 6'b100000), PCSrc=00, PCWre=1, zero-wait memory → imem_req at cycle 2 with addr 0; EXEC shows OpCode=0, func=6'h20; pc becomes 4, retired=1; next imem_addr=4.
- PC=0x10, BEQ with immediate 16'hFFFE, PCSrc=01 → pc becomes 0x0C. Repeat with 16'h0003 → pc becomes 0x20.
- PC=0x0000_0040, J with IR[25:0]=26'h000_0100, PCSrc=10 → pc becomes 0x0000_0400.
- HALT opcode 6'b111111 with PCWre=0 → halted=1 from the next cycle; no further imem_req over 20 cycles; retired and pc frozen.
- Memory delays rvalid 5 cycles → stays in WAIT, instr_valid=0 throughout, single EXEC afterwards. Reset pulsed during WAIT, then a late rvalid → ignored; clean restart at RESET_PC.
- RESET_PC=32'hFFFF_FFFC, PCSrc=00 → pc wraps to 0; next imem_addr=0.
